cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 197 +++++++++++++++++++
 tb/tb_cpu_core.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Multi-cycle accumulator-free CPU core: IDLE/EXEC/MEM/WB/HALT sequencing with a small
// register file and a req/ack data-memory port. Define CPU_CORE_MUL_EN to add MUL (0x0A).
//
//   state | meaning
//   IDLE  | ins_ready high (after the first post-reset edge), waiting for ins_valid
//   EXEC  | decode latched instruction, compute ALU result / branch / memory request
//   MEM   | mem_req held with stable addr/we/wdata until mem_ack is sampled high
//   WB    | write rd (unless r0), advance or redirect pc, return to IDLE
//   HALT  | halted=1, ins_ready=0 until reset

module cpu_core #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int PC_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ins_in,
    input  logic              ins_valid,
    output logic              ins_ready,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal
);

    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_LDI  = 8'h06;
    localparam logic [7:0] OP_LD   = 8'h07;
    localparam logic [7:0] OP_ST   = 8'h08;
    localparam logic [7:0] OP_BEQ  = 8'h09;
`ifdef CPU_CORE_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'h0A;
`endif
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                          run;
    logic [31:0]                   ins_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]             wb_data;
    logic                          wb_wr;
    logic                          wb_taken;

    logic [7:0]        ins_op;
    logic [7:0]        ins_imm;
    logic [RIDX_W-1:0] rd_idx;
    logic [RIDX_W-1:0] rs1_idx;
    logic [RIDX_W-1:0] rs2_idx;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              unused_fields;

    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              op_legal;
    logic              br_taken;
    logic              is_mem_op;

    assign ins_op  = ins_q[31:24];
    assign ins_imm = ins_q[7:0];
    assign rd_idx  = ins_q[16 +: RIDX_W];
    assign rs1_idx = ins_q[8 +: RIDX_W];
    assign rs2_idx = ins_q[0 +: RIDX_W];
    // Upper register-field bits beyond the register index are deliberately ignored.
    assign unused_fields = ^ins_q[23:8];

    assign rd_val  = regs[rd_idx];
    assign rs1_val = regs[rs1_idx];
    assign rs2_val = regs[rs2_idx];

    assign ins_ready = run && (state == IDLE);
    assign mem_req   = (state == MEM);
    assign halted    = (state == HALT);
    assign is_mem_op = (ins_op == OP_LD) || (ins_op == OP_ST);

    always_comb begin
        alu_res  = '0;
        alu_wr   = 1'b0;
        op_legal = 1'b1;
        br_taken = 1'b0;
        case (ins_op)
            OP_NOP:  ;
            OP_ADD:  begin alu_res = rs1_val + rs2_val; alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = rs1_val - rs2_val; alu_wr = 1'b1; end
            OP_AND:  begin alu_res = rs1_val & rs2_val; alu_wr = 1'b1; end
            OP_OR:   begin alu_res = rs1_val | rs2_val; alu_wr = 1'b1; end
            OP_XOR:  begin alu_res = rs1_val ^ rs2_val; alu_wr = 1'b1; end
            OP_LDI:  begin alu_res = DATA_W'(ins_imm);  alu_wr = 1'b1; end
            OP_LD:   ;
            OP_ST:   ;
            OP_BEQ:  br_taken = (rd_val == rs1_val);
`ifdef CPU_CORE_MUL_EN
            OP_MUL:  begin alu_res = rs1_val * rs2_val; alu_wr = 1'b1; end
`endif
            OP_HALT: ;
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ins_valid && ins_ready) state_nxt = EXEC;
            EXEC: begin
                if (ins_op == OP_HALT) begin
                    state_nxt = HALT;
                end else if (is_mem_op) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM:  if (mem_ack) state_nxt = WB;
            WB:   state_nxt = IDLE;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            pc        <= '0;
            regs      <= '0;
            ins_q     <= '0;
            wb_data   <= '0;
            wb_wr     <= 1'b0;
            wb_taken  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            illegal   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (ins_valid && ins_ready) ins_q <= ins_in;
                end
                EXEC: begin
                    wb_data  <= alu_res;
                    wb_wr    <= alu_wr || (ins_op == OP_LD);
                    wb_taken <= br_taken;
                    if (!op_legal) illegal <= 1'b1;
                    if (is_mem_op) begin
                        mem_addr  <= rs1_val;
                        mem_we    <= (ins_op == OP_ST);
                        mem_wdata <= (ins_op == OP_ST) ? rd_val : '0;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (ins_op == OP_LD) wb_data <= mem_rdata;
                        mem_we <= 1'b0;
                    end
                end
                WB: begin
                    // r0 is hardwired to zero, so its write is simply dropped.
                    if (wb_wr && (rd_idx != '0)) regs[rd_idx] <= wb_data;
                    pc <= wb_taken ? PC_W'(ins_imm) : pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: instruction latency, ALU/LDI/LD/ST/BEQ, wrap cases,
// illegal/HALT behaviour and asynchronous reset in the middle of a memory access.

module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins_in;
    logic        ins_valid;
    logic        ins_ready;
    logic [7:0]  pc;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        halted;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    cpu_core #(.DATA_W(8), .NUM_REGS(8), .PC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins_in    (ins_in),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ins_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", ins_ready, 1);
    endtask

    // Non-memory instruction: accept, then expect ins_ready back after 3 edges.
    task automatic send(input string tag, input logic [31:0] ins, input logic [7:0] npc);
        int lat;
        wait_ready();
        ins_in    = ins;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        lat = 1;
        while (ins_ready !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_pc"}, pc, npc);
    endtask

    // Memory instruction: ack raised in the delay-th cycle of mem_req.
    task automatic send_mem(input string tag, input logic [31:0] ins, input int delay,
                            input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] rdata, input logic [7:0] npc);
        wait_ready();
        ins_in    = ins;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        chk({tag, "_exec_noreq"}, mem_req, 0);
        tick();
        for (int i = 0; i < delay; i++) begin
            chk({tag, "_req"}, mem_req, 1);
            chk({tag, "_we"}, mem_we, we);
            chk({tag, "_addr"}, mem_addr, addr);
            if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
            if (i == delay - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk({tag, "_req_drop"}, mem_req, 0);
        tick();
        chk({tag, "_ready"}, ins_ready, 1);
        chk({tag, "_pc"}, pc, npc);
    endtask

    initial begin
        rst       = 1'b0;
        ins_in    = '0;
        ins_valid = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", ins_ready, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_req", mem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        rst = 1'b1;
        #1 chk("rel_ready_pre_edge", ins_ready, 0);
        @(negedge clk);
        chk("rel_ready_first_edge", ins_ready, 1);

        // LDI/ADD with wrap, result observed through ST
        send("ldi_r1_ff", 32'h06_01_00_FF, 8'h01);
        send("ldi_r2_02", 32'h06_02_00_02, 8'h02);
        send("add_r3",    32'h01_03_01_02, 8'h03);
        send_mem("st_r3", 32'h08_03_00_00, 1, 1'b1, 8'h00, 8'h01, 8'h00, 8'h04);

        // Store with 4-cycle ack delay, then load back
        send("ldi_r1_05", 32'h06_01_00_05, 8'h05);
        send_mem("st_r1_d4", 32'h08_01_00_00, 4, 1'b1, 8'h00, 8'h05, 8'h00, 8'h06);
        send_mem("ld_r4",    32'h07_04_00_00, 2, 1'b0, 8'h00, 8'h00, 8'h05, 8'h07);
        send_mem("st_r4",    32'h08_04_00_00, 1, 1'b1, 8'h00, 8'h05, 8'h00, 8'h08);

        // Upper register-field bits ignored (rd=0x0E -> r6); r0 stays zero
        send("ldi_r14_33", 32'h06_0E_00_33, 8'h09);
        send_mem("st_r6",  32'h08_06_00_00, 1, 1'b1, 8'h00, 8'h33, 8'h00, 8'h0A);
        send("ldi_r0_77",  32'h06_00_00_77, 8'h0B);
        send_mem("st_r0",  32'h08_00_00_00, 1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h0C);

        // SUB wrap, AND, XOR
        send("ldi_r2_01", 32'h06_02_00_01, 8'h0D);
        send("sub_r5",    32'h02_05_00_02, 8'h0E);
        send_mem("st_r5", 32'h08_05_00_00, 1, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h0F);
        send("and_r2",    32'h03_02_01_06, 8'h10);
        send_mem("st_and",32'h08_02_00_00, 1, 1'b1, 8'h00, 8'h01, 8'h00, 8'h11);
        send("xor_r2",    32'h05_02_01_06, 8'h12);
        send_mem("st_xor",32'h08_02_00_00, 1, 1'b1, 8'h00, 8'h36, 8'h00, 8'h13);

        // Load via nonzero address register, store to another address
        send_mem("ld_r4_a33", 32'h07_04_06_00, 1, 1'b0, 8'h33, 8'h00, 8'hA5, 8'h14);
        send_mem("st_r4_a05", 32'h08_04_01_00, 1, 1'b1, 8'h05, 8'hA5, 8'h00, 8'h15);

        // Branches
        send("beq_taken",     32'h09_00_00_40, 8'h40);
        send("beq_not_taken", 32'h09_01_00_10, 8'h41);

        // MUL
        send("ldi_r5_07", 32'h06_05_00_07, 8'h42);
        send("ldi_r6_06", 32'h06_06_00_06, 8'h43);
        send("mul_r7",    32'h0A_07_05_06, 8'h44);
`ifdef CPU_CORE_MUL_EN
        chk("mul_illegal", illegal, 0);
        send_mem("st_r7", 32'h08_07_00_00, 1, 1'b1, 8'h00, 8'h2A, 8'h00, 8'h45);
`else
        chk("mul_illegal", illegal, 1);
        send_mem("st_r7", 32'h08_07_00_00, 1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h45);
`endif

        // pc wrap at 0xFF
        send("beq_to_ff", 32'h09_00_00_FF, 8'hFF);
        send("nop_wrap",  32'h00_00_00_00, 8'h00);

        // Undefined opcode: NOP + sticky illegal
        send("op_3c", 32'h3C_01_05_06, 8'h01);
        chk("illegal_set", illegal, 1);
        send_mem("st_r1_keep", 32'h08_01_00_00, 1, 1'b1, 8'h00, 8'h05, 8'h00, 8'h02);
        chk("illegal_sticky", illegal, 1);

        // HALT with ins_valid held high
        wait_ready();
        ins_in    = 32'hFF_00_00_00;
        ins_valid = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("halt_halted", halted, 1);
            chk("halt_ready", ins_ready, 0);
            tick();
        end
        chk("halt_pc", pc, 8'h02);
        ins_valid = 1'b0;

        // Reset out of HALT
        #2 rst = 1'b0;
        #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_illegal", illegal, 0);
        chk("rst2_pc", pc, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_ready", ins_ready, 1);

        // Reset asserted in the middle of a memory access
        send("ldi_r1_09", 32'h06_01_00_09, 8'h01);
        wait_ready();
        ins_in    = 32'h08_01_01_00;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        chk("mm_req_before", mem_req, 1);
        chk("mm_addr_before", mem_addr, 8'h09);
        #2 rst = 1'b0;
        #1;
        chk("mm_req_async", mem_req, 0);
        chk("mm_we_async", mem_we, 0);
        chk("mm_addr_async", mem_addr, 8'h00);
        chk("mm_wdata_async", mem_wdata, 8'h00);
        chk("mm_pc_async", pc, 8'h00);
        chk("mm_ready_async", ins_ready, 0);
        @(negedge clk);
        mem_ack = 1'b1;
        rst = 1'b1;
        #1 chk("mm_ready_pre_edge", ins_ready, 0);
        @(negedge clk);
        chk("mm_ready_first_edge", ins_ready, 1);
        chk("mm_req_after", mem_req, 0);

        // mem_ack held high outside MEM is ignored
        send("ldi_ack_hi", 32'h06_02_00_03, 8'h01);
        chk("ack_hi_noreq", mem_req, 0);
        mem_ack = 1'b0;
        send_mem("st_r1_cleared", 32'h08_01_00_00, 1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
